// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared widths, defaults and the retirement record type for the WB tracer
package wb_trace_pkg;
    localparam int XLEN         = 32;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_AF_SLACK = 2;
    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_wdata;
        logic            trap;
    } trace_rec_t;
endpackage

// File: rtl/wb_retire_tracer_if.sv
// wb_retire_tracer_if: writeback-stage retirement inputs and the valid/ready trace record port
interface wb_retire_tracer_if;
    import wb_trace_pkg::*;
    logic            wb_valid_i;
    logic [XLEN-1:0] wb_pc_i;
    logic [31:0]     wb_insn_i;
    logic            wb_we_i;
    logic [4:0]      wb_dst_i;
    logic [XLEN-1:0] wb_r_i;
    logic            wb_trap_i;
    logic            trc_valid_o;
    logic            trc_ready_i;
    logic [63:0]     trc_order_o;
    logic [XLEN-1:0] trc_pc_o;
    logic [31:0]     trc_insn_o;
    logic [4:0]      trc_rd_o;
    logic [XLEN-1:0] trc_rd_wdata_o;
    logic            trc_trap_o;
    modport slave (
        input  wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, wb_trap_i, trc_ready_i,
        output trc_valid_o, trc_order_o, trc_pc_o, trc_insn_o, trc_rd_o, trc_rd_wdata_o, trc_trap_o
    );
    modport master (
        output wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, wb_trap_i, trc_ready_i,
        input  trc_valid_o, trc_order_o, trc_pc_o, trc_insn_o, trc_rd_o, trc_rd_wdata_o, trc_trap_o
    );
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: first-word fall-through FIFO of trace records; head reads as zero when empty
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t din,
    output trace_rec_t dout,
    output logic       full,
    output logic       empty,
    output logic [AW:0] level
);
    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_pop;
    assign do_pop = pop && !empty;
    assign empty  = level == '0;
    assign full   = level == (AW+1)'(DEPTH);
    assign dout   = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/wb_retire_tracer.sv
// wb_retire_tracer: stamps and buffers every WB retirement, flags almost-full and counts dropped records
module wb_retire_tracer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_SLACK = DEF_AF_SLACK,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_retire_tracer_if.slave    trc,
    input  logic                 clear_i,
    output logic                 stall_req_o,
    output logic                 overflow_o,
    output logic [15:0]          drop_cnt_o,
    output logic [LW-1:0]        level_o
);
    logic [63:0] order;
    logic        full, empty, pop, push, drop;
    logic [4:0]  rd;
    trace_rec_t  din, dout;
    assign pop  = !empty && trc.trc_ready_i;
    assign push = trc.wb_valid_i && (!full || pop);
    assign drop = trc.wb_valid_i && full && !pop;
    assign rd   = (trc.wb_we_i && !trc.wb_trap_i && trc.wb_dst_i != 5'd0) ? trc.wb_dst_i : 5'd0;
    assign din  = '{order: order, pc: trc.wb_pc_i, insn: trc.wb_insn_i, rd: rd,
                    rd_wdata: (rd != 5'd0) ? trc.wb_r_i : '0, trap: trc.wb_trap_i};
    // order advances on every retirement so dropped records leave visible gaps
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            order      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (trc.wb_valid_i) order <= order + 64'd1;
            overflow_o <= drop || (overflow_o && !clear_i);
            drop_cnt_o <= drop ? (clear_i ? 16'd1 : drop_cnt_o + {15'd0, drop_cnt_o != 16'hFFFF})
                               : (clear_i ? 16'd0 : drop_cnt_o);
        end
    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );
    assign stall_req_o        = (LW'(DEPTH) - level_o) <= LW'(AF_SLACK);
    assign trc.trc_valid_o    = !empty;
    assign trc.trc_order_o    = dout.order;
    assign trc.trc_pc_o       = dout.pc;
    assign trc.trc_insn_o     = dout.insn;
    assign trc.trc_rd_o       = dout.rd;
    assign trc.trc_rd_wdata_o = dout.rd_wdata;
    assign trc.trc_trap_o     = dout.trap;
endmodule

// File: tb/tb_wb_retire_tracer.sv
// tb_wb_retire_tracer: directed vector table plus fill/drain/clear/reset sequences for wb_retire_tracer
module tb_wb_retire_tracer;
    import wb_trace_pkg::*;
    localparam int DEPTH = 8;
    localparam int AF    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        stall, ovf;
    logic [15:0] dcnt;
    logic [3:0]  level;
    int          passed = 0;
    int          total  = 0;

    wb_retire_tracer_if bus ();

    wb_retire_tracer #(.DEPTH(DEPTH), .AF_SLACK(AF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trc         (bus.slave),
        .clear_i     (clear),
        .stall_req_o (stall),
        .overflow_o  (ovf),
        .drop_cnt_o  (dcnt),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc, insn;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] r;
        logic        trap, ready;
        logic        ev;
        logic [63:0] eorder;
        logic [31:0] epc;
        logic [4:0]  erd;
        logic [31:0] ewd;
        logic        etrap;
        logic [3:0]  elevel;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic we,
                          input logic [4:0] dst, input logic [31:0] r, input logic trap);
        bus.wb_valid_i = 1'b1;
        bus.wb_pc_i    = pc;
        bus.wb_insn_i  = insn;
        bus.wb_we_i    = we;
        bus.wb_dst_i   = dst;
        bus.wb_r_i     = r;
        bus.wb_trap_i  = trap;
    endtask

    task automatic idle();
        bus.wb_valid_i = 1'b0;
        bus.wb_pc_i    = '0;
        bus.wb_insn_i  = '0;
        bus.wb_we_i    = 1'b0;
        bus.wb_dst_i   = '0;
        bus.wb_r_i     = '0;
        bus.wb_trap_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        bus.trc_ready_i = 1'b0;
        #2;
        check("reset_valid", bus.trc_valid_o, 0);
        check("reset_level", level, 0);
        check("reset_stall", stall, 0);
        check("reset_ovf", ovf, 0);
        check("reset_dcnt", dcnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        vt[0] = '{1, 32'h200, 32'h00500093, 1, 1, 32'h5, 0, 1,      1, 0, 32'h200, 1, 32'h5, 0, 1};
        vt[1] = '{0, 0, 0, 0, 0, 0, 0, 1,                           0, 0, 0, 0, 0, 0, 0};
        vt[2] = '{1, 32'h204, 32'h00000013, 1, 0, 32'hDEAD, 0, 1,   1, 1, 32'h204, 0, 0, 0, 1};
        vt[3] = '{1, 32'h208, 32'h00000073, 1, 3, 32'h1234, 1, 1,   1, 2, 32'h208, 0, 0, 1, 1};
        vt[4] = '{1, 32'h20c, 32'h00a00193, 1, 3, 32'hA, 0, 1,      1, 3, 32'h20c, 3, 32'hA, 0, 1};
        vt[5] = '{0, 0, 0, 0, 0, 0, 0, 1,                           0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            if (vt[i].v) retire(vt[i].pc, vt[i].insn, vt[i].we, vt[i].dst, vt[i].r, vt[i].trap);
            else idle();
            bus.trc_ready_i = vt[i].ready;
            step();
            check($sformatf("v%0d_valid", i), bus.trc_valid_o, vt[i].ev);
            check($sformatf("v%0d_order", i), bus.trc_order_o, vt[i].eorder);
            check($sformatf("v%0d_pc", i), bus.trc_pc_o, vt[i].epc);
            check($sformatf("v%0d_rd", i), bus.trc_rd_o, vt[i].erd);
            check($sformatf("v%0d_wdata", i), bus.trc_rd_wdata_o, vt[i].ewd);
            check($sformatf("v%0d_trap", i), bus.trc_trap_o, vt[i].etrap);
            check($sformatf("v%0d_level", i), level, vt[i].elevel);
        end

        // fill past capacity with the consumer stalled
        do_reset();
        bus.trc_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int el;
            retire(32'h1000 + 32'(4 * i), 32'h00000093, 1, 5'(i + 1), 32'h100 + 32'(i), 0);
            step();
            el = (i < 8) ? i + 1 : 8;
            check($sformatf("fill%0d_level", i), level, 64'(el));
            check($sformatf("fill%0d_stall", i), stall, 64'((DEPTH - el) <= AF));
            check($sformatf("fill%0d_ovf", i), ovf, 64'(i >= 8));
            check($sformatf("fill%0d_dcnt", i), dcnt, (i >= 8) ? 64'(i - 7) : 64'd0);
            check($sformatf("fill%0d_head_order", i), bus.trc_order_o, 0);
            check($sformatf("fill%0d_head_pc", i), bus.trc_pc_o, 32'h1000);
        end
        idle();
        bus.trc_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_order", i), bus.trc_order_o, 64'(i));
            check($sformatf("drain%0d_pc", i), bus.trc_pc_o, 32'h1000 + 32'(4 * i));
            check($sformatf("drain%0d_wdata", i), bus.trc_rd_wdata_o, 32'h100 + 32'(i));
            step();
        end
        check("drain_level", level, 0);

        bus.trc_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            retire(32'h3000 + 32'(4 * i), 32'h00000093, 1, 5'd2, 32'(i), 0);
            step();
            if (i == 0) check("after_drop_order", bus.trc_order_o, 10);
        end
        check("refill_level", level, 8);

        // full with simultaneous push and pop
        bus.trc_ready_i = 1'b1;
        retire(32'h4000, 32'h00000093, 1, 5'd9, 32'h99, 0);
        step();
        check("pp_level", level, 8);
        check("pp_dcnt", dcnt, 2);
        check("pp_head", bus.trc_order_o, 11);
        idle();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_drain%0d", i), bus.trc_order_o, 64'(11 + i));
            if (i == 7) begin
                check("pp_last_pc", bus.trc_pc_o, 32'h4000);
                check("pp_last_rd", bus.trc_rd_o, 9);
                check("pp_last_wdata", bus.trc_rd_wdata_o, 32'h99);
            end
            step();
        end

        // clear racing a drop, then clear alone
        bus.trc_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            retire(32'h5000 + 32'(4 * i), 32'h00000093, 1, 5'd4, 32'(i), 0);
            step();
        end
        retire(32'h6000, 32'h00000093, 1, 5'd4, 32'h1, 0);
        clear = 1'b1;
        step();
        check("clr_drop_ovf", ovf, 1);
        check("clr_drop_dcnt", dcnt, 1);
        idle();
        step();
        clear = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_dcnt", dcnt, 0);
        check("clr_level", level, 8);

        // backpressure stability, then asynchronous reset mid-stream
        retire(32'h7000, 32'h00000093, 1, 5'd5, 32'h55, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp%0d_order", i), bus.trc_order_o, 19);
            check($sformatf("bp%0d_pc", i), bus.trc_pc_o, 32'h5000);
            check($sformatf("bp%0d_rd", i), bus.trc_rd_o, 4);
            check($sformatf("bp%0d_valid", i), bus.trc_valid_o, 1);
        end
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.trc_valid_o, 0);
        check("arst_order", bus.trc_order_o, 0);
        check("arst_pc", bus.trc_pc_o, 0);
        check("arst_level", level, 0);
        check("arst_stall", stall, 0);
        check("arst_ovf", ovf, 0);
        check("arst_dcnt", dcnt, 0);
        idle();
        step();
        rst_n = 1'b1;
        retire(32'h8000, 32'h00500093, 1, 5'd1, 32'h5, 0);
        step();
        check("post_rst_order", bus.trc_order_o, 0);
        check("post_rst_pc", bus.trc_pc_o, 32'h8000);
        check("post_rst_level", level, 1);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_retire_tracer.md
# wb_retire_tracer

Retirement trace collector on the writeback-stage outputs of the RV12 core. It samples every non-bubble instruction leaving WB and normalises the register-write information. Each retirement is tagged with a 64-bit monotonic order number and buffered in a small FIFO behind a valid/ready port, which feeds the formal checker and the simulation trace sink. The block also raises a stall request before the buffer fills and reports any records it had to drop.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- XLEN, 32, data/PC width
- AF_SLACK, 2, stall_req_o asserts when free entries ≤ AF_SLACK; range 0..DEPTH-1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid_i  in  1  non-bubble instruction retires this cycle
- wb_pc_i  in  XLEN  PC of retiring instruction
- wb_insn_i  in  32  instruction word
- wb_we_i  in  1  register-file write enable
- wb_dst_i  in  5  destination register index
- wb_r_i  in  XLEN  writeback value
- wb_trap_i  in  1  instruction retired with exception
- clear_i  in  1  synchronous clear of overflow_o and drop_cnt_o
- trc_valid_o  out  1  record available
- trc_ready_i  in  1  consumer accepts record
- trc_order_o  out  64  retirement order number
- trc_pc_o  out  XLEN  record PC
- trc_insn_o  out  32  record instruction
- trc_rd_o  out  5  effective destination register; 0 = no write
- trc_rd_wdata_o  out  XLEN  written value; 0 when trc_rd_o == 0
- trc_trap_o  out  1  record is a trap
- stall_req_o  out  1  almost-full indication to pipeline control
- overflow_o  out  1  sticky: at least one record dropped
- drop_cnt_o  out  16  dropped-record count, saturates at 16'hFFFF
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Normalisation at capture:
  - rd = (wb_we_i && !wb_trap_i && wb_dst_i != 0) ? wb_dst_i : 0
  - wdata = (rd != 0) ? wb_r_i : 0
  - pc, insn and trap are passed through unchanged.
- Order counter starts at 0 and is stamped into the record. It increments by 1 on every wb_valid_i, whether or not the record is accepted, so drops show as gaps. It wraps modulo 2^64.
- Pop = trc_valid_o && trc_ready_i.
- Push = wb_valid_i && (level < DEPTH || pop).
- Full with simultaneous pop: the push is accepted and level is unchanged.
- Drop = wb_valid_i && level == DEPTH && !pop. On a drop:
  - overflow_o is set.
  - drop_cnt_o increments, saturating at 16'hFFFF.
  - FIFO contents are untouched.
- clear_i clears overflow_o and drop_cnt_o. If a drop occurs in the same cycle, the drop wins: overflow_o = 1 and drop_cnt_o = 1.
- FIFO is first-word fall-through. Output fields show the head entry and stay stable while trc_valid_o && !trc_ready_i. trc_valid_o = (level != 0).
- stall_req_o = (DEPTH - level) ≤ AF_SLACK. It is combinational from registered level.
- The block is advisory: it never back-pressures WB itself.

## Timing
- Reset values:
  - All outputs 0.
  - Order counter 0; read/write pointers 0; level 0.
  - stall_req_o = 1 only if AF_SLACK ≥ DEPTH, which is illegal, so it resets to 0.
- Latency: a push in cycle N makes the record visible on trc_* in cycle N+1. There is no same-cycle bypass, even when the FIFO is empty.
- Pointers wrap modulo DEPTH. level is updated as +1 (push only), −1 (pop only), or 0 (both or neither).
- Reset mid-operation discards all entries immediately (asynchronous). The order counter restarts at 0.

## Structure
- Package wb_trace_pkg holds:
  - trace_rec_t struct {order[63:0], pc, insn, rd, rd_wdata, trap}, parameterised via XLEN localparam.
  - Default DEPTH/AF_SLACK constants.
- One sub-module, trace_fifo: a generic FWFT synchronous FIFO of trace_rec_t. It has push/pop/full/empty/level ports.
- The top module keeps the following outside the FIFO:
  - Normalisation.
  - Order counter.
  - Drop logic, overflow_o and drop_cnt_o.
  - stall_req_o.

## Test plan
- Single retire: PC 0x200, insn 0x00500093 (addi x1,x0,5), we=1, dst=1, r=5, ready=1 → next cycle valid=1, order=0, rd=1, wdata=5; level returns to 0 after the pop.
- Normalisation:
  - dst=0 with we=1, r=0xDEAD → rd=0, wdata=0.
  - trap=1 with we=1, dst=3 → rd=0, trap=1.
- Fill: DEPTH=8, ready=0, 10 consecutive retires →
  - level=8, stall_req_o from level 6.
  - overflow_o=1, drop_cnt_o=2.
  - With ready then set to 1, the drained orders are 0..7.
  - The next accepted retire carries order 10.
- Full with simultaneous push+pop: level stays 8, no drop, the new record appears last.
- clear_i with a simultaneous drop → overflow_o=1, drop_cnt_o=1. clear_i alone → both 0.
- Backpressure stability: valid=1, ready=0 for 5 cycles → all trc_* fields constant. Then assert rst_n=0 mid-stream → all outputs 0 asynchronously, and after release the first order is 0.
